// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide: 34-cycle latency, 1 cycle for divide-by-zero/overflow.
// Result is held in RESP until Res_Ack; Busy stalls EX from the request cycle until the ack cycle.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Req_Valid,
    input  logic [2:0]       Req_Funct3,
    input  logic [WIDTH-1:0] Req_A,
    input  logic [WIDTH-1:0] Req_B,
    input  logic             Flush,
    input  logic             Res_Ack,
    output logic             Req_Ready,
    output logic             Busy,
    output logic             Res_Valid,
    output logic [WIDTH-1:0] Res_Data
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, RESP} state_t;

    state_t             state_q, state_nxt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               sa_q, sb_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   res_q;

    // Request decode and special-case detection
    logic             a_signed, b_signed, neg_a, neg_b, is_div;
    logic             div_zero, div_ovf, special, accept;
    logic [WIDTH-1:0] abs_a, abs_b, special_res;

    assign is_div   = Req_Funct3[2];
    assign a_signed = (Req_Funct3 == 3'b000) || (Req_Funct3 == 3'b001) || (Req_Funct3 == 3'b010) ||
                      (Req_Funct3 == 3'b100) || (Req_Funct3 == 3'b110);
    assign b_signed = (Req_Funct3 == 3'b000) || (Req_Funct3 == 3'b001) ||
                      (Req_Funct3 == 3'b100) || (Req_Funct3 == 3'b110);
    assign neg_a    = a_signed && Req_A[WIDTH-1];
    assign neg_b    = b_signed && Req_B[WIDTH-1];
    assign abs_a    = neg_a ? -Req_A : Req_A;
    assign abs_b    = neg_b ? -Req_B : Req_B;
    assign div_zero = is_div && (Req_B == '0);
    assign div_ovf  = is_div && !Req_Funct3[0] && (Req_A == MIN_NEG) && (Req_B == ALL_ONE);
    assign special  = div_zero || div_ovf;
    assign accept   = (state_q == IDLE) && Req_Valid && !Flush;

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = Req_Funct3[1] ? Req_A : ALL_ONE;
        else
            special_res = Req_Funct3[1] ? '0 : MIN_NEG;
    end

    // Multiply shifts B right and accumulates into the upper half; divide shifts A left into
    // the partial remainder held in acc_q[hi], quotient bits enter acc_q[lo] from the right.
    logic [WIDTH:0] mul_sum, div_rem, div_diff;
    logic           q_bit;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    assign div_rem  = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    assign div_diff = div_rem - {1'b0, b_q};
    assign q_bit    = !div_diff[WIDTH];

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem, fix_res;

    assign prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign quot = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        fix_res = '0;
        case (op_q)
            3'b000:                 fix_res = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_res = quot;
            default:                fix_res = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        Busy      = 1'b0;
        case (state_q)
            IDLE: begin
                Busy = Req_Valid;
                if (Req_Valid) state_nxt = special ? RESP : CALC;
            end
            CALC: begin
                Busy = 1'b1;
                if (cnt_q == CW'(WIDTH-1)) state_nxt = FIX;
            end
            FIX: begin
                Busy      = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                Busy = !Res_Ack;
                if (Res_Ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (Flush) begin
            state_nxt = IDLE;
            Busy      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            acc_q <= '0;
            cnt_q <= '0;
            res_q <= '0;
        end else if (accept) begin
            op_q  <= Req_Funct3;
            a_q   <= abs_a;
            b_q   <= abs_b;
            sa_q  <= neg_a;
            sb_q  <= neg_b;
            acc_q <= '0;
            cnt_q <= '0;
            if (special) res_q <= special_res;
        end else if (state_q == CALC && !Flush) begin
            cnt_q <= cnt_q + 1'b1;
            if (op_q[2]) begin
                acc_q <= {(q_bit ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0]),
                          acc_q[WIDTH-2:0], q_bit};
                a_q   <= {a_q[WIDTH-2:0], 1'b0};
            end else begin
                acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
                b_q   <= {1'b0, b_q[WIDTH-1:1]};
            end
        end else if (state_q == FIX && !Flush) begin
            res_q <= fix_res;
        end
    end

    assign Req_Ready = (state_q == IDLE);
    assign Res_Valid = (state_q == RESP);
    assign Res_Data  = res_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: latency, results, flush, backpressure and reset.
module tb_ex_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Req_Valid = 1'b0;
    logic [2:0]  Req_Funct3 = 3'b000;
    logic [31:0] Req_A = '0;
    logic [31:0] Req_B = '0;
    logic        Flush = 1'b0;
    logic        Res_Ack = 1'b0;
    logic        Req_Ready, Busy, Res_Valid;
    logic [31:0] Res_Data;

    int total = 0;
    int bad   = 0;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .Req_Valid(Req_Valid), .Req_Funct3(Req_Funct3),
        .Req_A(Req_A), .Req_B(Req_B), .Flush(Flush), .Res_Ack(Res_Ack),
        .Req_Ready(Req_Ready), .Busy(Busy), .Res_Valid(Res_Valid), .Res_Data(Res_Data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request in IDLE, accept it, and wait for Res_Valid; leaves the unit in RESP.
    task automatic start_wait(input string tag, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        int lat;
        Req_Valid  = 1'b1;
        Req_Funct3 = f3;
        Req_A      = a;
        Req_B      = b;
        #1;
        chk({tag, "_busy_req"}, {31'b0, Busy}, 32'd1);
        tick();
        Req_Valid = 1'b0;
        lat = 1;
        while (!Res_Valid && lat < 100) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_data"}, Res_Data, exp_res);
    endtask

    task automatic ack(input string tag, input logic [31:0] exp_res);
        Res_Ack = 1'b1;
        #1;
        chk({tag, "_busy_ack"}, {31'b0, Busy}, 32'd0);
        tick();
        Res_Ack = 1'b0;
        chk({tag, "_idle_after_ack"}, {30'b0, Req_Ready, Res_Valid}, 32'b10);
        chk({tag, "_data_kept"}, Res_Data, exp_res);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        start_wait(tag, f3, a, b, exp_lat, exp_res);
        ack(tag, exp_res);
    endtask

    initial begin
        int seen;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("reset_ready", {31'b0, Req_Ready}, 32'd1);
        chk("reset_valid", {31'b0, Res_Valid}, 32'd0);
        chk("reset_data", Res_Data, 32'd0);
        chk("reset_busy", {31'b0, Busy}, 32'd0);
        tick();

        run_op("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 34, 32'hFFFF_FFEB);
        run_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000);
        run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE);
        run_op("mulhsu_m1_2", 3'b010, 32'hFFFF_FFFF, 32'd2, 34, 32'hFFFF_FFFF);
        run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD);
        run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF);
        run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 34, 32'd14);
        run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 34, 32'd2);

        run_op("div_by_zero", 3'b100, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
        run_op("remu_by_zero", 3'b111, 32'd5, 32'd0, 1, 32'd5);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);

        // Flush in cycle 10 of a multiply, then an immediate new request
        Req_Valid  = 1'b1;
        Req_Funct3 = 3'b000;
        Req_A      = 32'd1000;
        Req_B      = 32'd3;
        tick();
        Req_Valid = 1'b0;
        seen = 0;
        repeat (9) begin
            if (Res_Valid) seen++;
            tick();
        end
        chk("flush_ready_in_calc", {31'b0, Req_Ready}, 32'd0);
        Flush = 1'b1;
        #1;
        chk("flush_busy_low", {31'b0, Busy}, 32'd0);
        tick();
        Flush = 1'b0;
        chk("flush_idle", {30'b0, Req_Ready, Res_Valid}, 32'b10);
        run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 34, 32'd12);

        Req_Valid = 1'b1;
        Flush     = 1'b1;
        Req_Funct3 = 3'b000;
        #1;
        chk("flush_req_busy", {31'b0, Busy}, 32'd0);
        tick();
        Req_Valid = 1'b0;
        Flush     = 1'b0;
        #1;
        chk("flush_req_not_accepted", {30'b0, Req_Ready, Busy}, 32'b10);
        tick();

        // Result held while Res_Ack stays low
        start_wait("bp_divu", 3'b101, 32'd100, 32'd7, 34, 32'd14);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold", {Res_Data[29:0], Res_Valid, Busy}, {30'd14, 1'b1, 1'b1});
        end
        ack("bp_divu", 32'd14);

        // Synchronous reset in cycle 20 of a divide
        Req_Valid  = 1'b1;
        Req_Funct3 = 3'b101;
        Req_A      = 32'd1000;
        Req_B      = 32'd9;
        tick();
        Req_Valid = 1'b0;
        repeat (19) begin
            if (Res_Valid) seen++;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_ready", {31'b0, Req_Ready}, 32'd1);
        chk("rst_mid_data", Res_Data, 32'd0);
        chk("rst_mid_valid_busy", {30'b0, Res_Valid, Busy}, 32'd0);
        repeat (40) begin
            if (Res_Valid) seen++;
            tick();
        end
        chk("no_result_after_abort", seen, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
